// File: rtl/lcd_8080_writer.sv
// -----------------------------------------------------------------------------
// lcd_8080_writer
//
// Back-end of the LCD DMA path. Takes a stream of 16-bit command/data words
// and plays each one out on an 8080-style parallel write bus with
// programmable setup, strobe-low and strobe-high timing. Chip select stays
// low across back-to-back words and is released after CS_HOLD idle cycles.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   enable         1 = accept new words; 0 = finish current word, take no more
//   in_valid       upstream word available
//   in_ready       block can accept a word this cycle (combinational)
//   in_data        pixel or command word
//   in_dc          1 = data word, 0 = command word
//   lcd_cs_n       chip select, active low
//   lcd_d_c_n      data/command select (1 = data)
//   lcd_wr_n       write strobe, active low; LCD latches on its rising edge
//   lcd_data       parallel data bus
//   busy           1 whenever the state machine is not IDLE
//   words_written  count of completed strobes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module lcd_8080_writer #(
    parameter int DATA_W    = 16,
    parameter int T_SETUP   = 1,
    parameter int T_WR_LOW  = 2,
    parameter int T_WR_HIGH = 2,
    parameter int CS_HOLD   = 4,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dc,
    output logic              lcd_cs_n,
    output logic              lcd_d_c_n,
    output logic              lcd_wr_n,
    output logic [DATA_W-1:0] lcd_data,
    output logic              busy,
    output logic [CNT_W-1:0]  words_written
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } state_t;

    // One shared phase timer, sized for the longest phase.
    localparam int T_MAX_A = (T_SETUP  > T_WR_LOW) ? T_SETUP  : T_WR_LOW;
    localparam int T_MAX_B = (T_WR_HIGH > CS_HOLD) ? T_WR_HIGH : CS_HOLD;
    localparam int T_MAX   = (T_MAX_A  > T_MAX_B)  ? T_MAX_A  : T_MAX_B;
    localparam int TIM_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Terminal counts: the timer runs 0..N-1 within an N-cycle phase.
    localparam logic [TIM_W-1:0] SETUP_LAST = TIM_W'(T_SETUP - 1);
    localparam logic [TIM_W-1:0] LOW_LAST   = TIM_W'(T_WR_LOW - 1);
    localparam logic [TIM_W-1:0] HIGH_LAST  = TIM_W'(T_WR_HIGH - 1);
    localparam logic [TIM_W-1:0] HOLD_LAST  = TIM_W'(CS_HOLD - 1);

    state_t           state;
    logic [TIM_W-1:0] tim;
    logic             accept;

    // in_ready is deliberately combinational so a word can be taken on the
    // very edge a phase sequence ends, giving the T_SETUP+T_WR_LOW+T_WR_HIGH+1
    // back-to-back period.
    assign in_ready = ((state == IDLE) || (state == HOLD)) && enable && !reset;
    assign accept   = in_valid && in_ready;

    // NOTE: every register below is assigned with <= so all of them update
    // together from values sampled before the edge; a blocking = here would
    // let later statements see half-updated state and break simulation/synthesis
    // equivalence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tim           <= '0;
            lcd_cs_n      <= 1'b1;
            lcd_wr_n      <= 1'b1;
            lcd_d_c_n     <= 1'b1;
            lcd_data      <= '0;
            busy          <= 1'b0;
            words_written <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lcd_data  <= in_data;
                        lcd_d_c_n <= in_dc;
                        lcd_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        tim       <= '0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (tim == SETUP_LAST) begin
                        lcd_wr_n <= 1'b0;
                        tim      <= '0;
                        state    <= LOW;
                    end else begin
                        tim <= tim + TIM_W'(1);
                    end
                end

                LOW: begin
                    // The LCD latches on this rising strobe, so the word
                    // counts as written here.
                    if (tim == LOW_LAST) begin
                        lcd_wr_n      <= 1'b1;
                        words_written <= words_written + CNT_W'(1);
                        tim           <= '0;
                        state         <= HIGH;
                    end else begin
                        tim <= tim + TIM_W'(1);
                    end
                end

                HIGH: begin
                    if (tim == HIGH_LAST) begin
                        tim   <= '0;
                        state <= HOLD;
                    end else begin
                        tim <= tim + TIM_W'(1);
                    end
                end

                HOLD: begin
                    // Bus and d_c_n keep the last word; an accept restarts the
                    // sequence and clears the idle count, otherwise cs_n is
                    // released after CS_HOLD consecutive idle cycles.
                    if (accept) begin
                        lcd_data  <= in_data;
                        lcd_d_c_n <= in_dc;
                        tim       <= '0;
                        state     <= SETUP;
                    end else if (tim == HOLD_LAST) begin
                        lcd_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        tim      <= '0;
                        state    <= IDLE;
                    end else begin
                        tim <= tim + TIM_W'(1);
                    end
                end

                default: begin
                    lcd_cs_n <= 1'b1;
                    lcd_wr_n <= 1'b1;
                    busy     <= 1'b0;
                    tim      <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_8080_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_8080_writer
//
// Directed bench for lcd_8080_writer. Instance dut uses default timing;
// instance dut_b uses CNT_W=4, T_SETUP=3, T_WR_LOW=1, T_WR_HIGH=1 for the
// counter-wrap and alternate-timing cases. Bus words are captured on every
// rising wr_n edge and compared against hand-listed expected sequences.
// -----------------------------------------------------------------------------
module tb_lcd_8080_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable;
    logic        in_valid, in_ready, in_dc;
    logic [15:0] in_data;
    logic        lcd_cs_n, lcd_d_c_n, lcd_wr_n, busy;
    logic [15:0] lcd_data;
    logic [31:0] words_written;

    logic        in_valid_b, in_ready_b, in_dc_b;
    logic [15:0] in_data_b;
    logic        lcd_cs_n_b, lcd_d_c_n_b, lcd_wr_n_b, busy_b;
    logic [15:0] lcd_data_b;
    logic [3:0]  words_written_b;

    lcd_8080_writer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_dc         (in_dc),
        .lcd_cs_n      (lcd_cs_n),
        .lcd_d_c_n     (lcd_d_c_n),
        .lcd_wr_n      (lcd_wr_n),
        .lcd_data      (lcd_data),
        .busy          (busy),
        .words_written (words_written)
    );

    lcd_8080_writer #(
        .T_SETUP   (3),
        .T_WR_LOW  (1),
        .T_WR_HIGH (1),
        .CNT_W     (4)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid_b),
        .in_ready      (in_ready_b),
        .in_data       (in_data_b),
        .in_dc         (in_dc_b),
        .lcd_cs_n      (lcd_cs_n_b),
        .lcd_d_c_n     (lcd_d_c_n_b),
        .lcd_wr_n      (lcd_wr_n_b),
        .lcd_data      (lcd_data_b),
        .busy          (busy_b),
        .words_written (words_written_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic [16:0] cap_q[$];
    int          cs_rise     = 0;
    int          bad_change  = 0;
    int          strobes_b   = 0;
    int          low_b       = 0;
    logic        prev_low    = 1'b0;
    logic [16:0] prev_bus    = '0;

    always @(posedge lcd_wr_n) cap_q.push_back({lcd_d_c_n, lcd_data});
    always @(posedge lcd_cs_n) cs_rise++;
    always @(posedge lcd_wr_n_b) strobes_b++;

    always @(negedge clk) begin
        if (lcd_wr_n_b === 1'b0) low_b++;
        if (prev_low && (lcd_wr_n === 1'b0) && ({lcd_d_c_n, lcd_data} !== prev_bus))
            bad_change++;
        prev_low = (lcd_wr_n === 1'b0);
        prev_bus = {lcd_d_c_n, lcd_data};
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait (bounded) for in_ready, return after the accept
    // edge. in_valid is left high so consecutive calls form a held stream.
    task automatic send(input bit b, input logic [15:0] d, input logic dc, output int acc_cyc);
        int waitc = 0;
        if (!b) begin
            in_valid = 1'b1; in_data = d; in_dc = dc;
        end else begin
            in_valid_b = 1'b1; in_data_b = d; in_dc_b = dc;
        end
        @(negedge clk);
        while (!(b ? in_ready_b : in_ready) && waitc < 100) begin
            waitc++;
            @(negedge clk);
        end
        check("accept_in_time", 32'(waitc < 100), 32'd1);
        acc_cyc = cyc;
        tick();
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_cs_n"},  lcd_cs_n,      1'b1);
        check({pfx, "_wr_n"},  lcd_wr_n,      1'b1);
        check({pfx, "_d_c_n"}, lcd_d_c_n,     1'b1);
        check({pfx, "_data"},  lcd_data,      16'h0000);
        check({pfx, "_busy"},  busy,          1'b0);
        check({pfx, "_count"}, words_written, 32'd0);
        check({pfx, "_ready"}, in_ready,      1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int a;
        int acc[8];
        int acc2[17];
        int ww0;

        reset = 1'b1; enable = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dc = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; in_dc_b = 1'b0;
        tick(); tick();

        // ---- reset state ----
        check_reset_state("rst");
        reset = 1'b0; enable = 1'b1;
        tick();
        cap_q.delete();
        cs_rise = 0;
        check("idle_ready", in_ready, 1'b1);

        // ---- single command word, default timing ----
        send(1'b0, 16'h002C, 1'b0, a);
        in_valid = 1'b0;
        check("single_cs_accept", lcd_cs_n,  1'b0);
        check("single_wr_setup",  lcd_wr_n,  1'b1);
        check("single_data",      lcd_data,  16'h002C);
        check("single_dc",        lcd_d_c_n, 1'b0);
        check("single_busy",      busy,      1'b1);
        check("single_ready_setup", in_ready, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            // wr_n low exactly on cycles 1 and 2 after the accept edge;
            // cs_n released 4 cycles after HOLD entry (cycle 5) -> cycle 9
            check($sformatf("single_wr_c%0d", k), lcd_wr_n, 1'((k == 1) || (k == 2)) ^ 1'b1);
            check($sformatf("single_cs_c%0d", k), lcd_cs_n, 1'(k == 9));
            if (k == 2) check("single_data_low", lcd_data, 16'h002C);
            if (k == 3) check("single_count", words_written, 32'd1);
            if (k == 5) check("single_ready_hold", in_ready, 1'b1);
        end
        check("single_busy_end", busy, 1'b0);
        check("single_caps", cap_q.size(), 32'd1);
        if (cap_q.size() > 0) check("single_cap0", 32'(cap_q[0]), 32'h0002C);

        // ---- burst of 8 data words, in_valid held high ----
        cap_q.delete();
        cs_rise = 0;
        ww0 = words_written;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 16'(16'h1111 * (i + 1)), 1'b1, a);
            acc[i] = a;
        end
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++)
            check($sformatf("burst_period_%0d", i), 32'(acc[i] - acc[i-1]), 32'd6);
        repeat (5) tick();
        check("burst_cs_held", cs_rise, 32'd0);
        check("burst_count", words_written, 32'(ww0 + 8));
        check("burst_caps", cap_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            check($sformatf("burst_cap%0d", i), 32'(cap_q[i]), 32'h10000 | 32'(16'h1111 * (i + 1)));
        repeat (4) tick();
        check("burst_cs_release", lcd_cs_n, 1'b1);

        // ---- enable dropped during LOW of word 3 of 5 ----
        cap_q.delete();
        ww0 = words_written;
        send(1'b0, 16'hA001, 1'b1, a);
        send(1'b0, 16'hA002, 1'b1, a);
        send(1'b0, 16'hA003, 1'b1, a);
        tick();
        check("en_w3_in_low", lcd_wr_n, 1'b0);
        enable  = 1'b0;
        in_data = 16'hA004;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("en_blocked_c%0d", k), in_ready, 1'b0);
        end
        check("en_cs_release", lcd_cs_n, 1'b1);
        check("en_busy_idle",  busy,     1'b0);
        check("en_count3", words_written, 32'(ww0 + 3));
        check("en_caps3",  cap_q.size(), 32'd3);
        enable = 1'b1;
        send(1'b0, 16'hA004, 1'b1, a);
        send(1'b0, 16'hA005, 1'b1, a);
        in_valid = 1'b0;
        repeat (10) tick();
        check("en_count5", words_written, 32'(ww0 + 5));
        check("en_caps5",  cap_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < cap_q.size(); i++)
            check($sformatf("en_cap%0d", i), 32'(cap_q[i]), 32'h1A001 + 32'(i));

        // ---- reset while wr_n is low ----
        send(1'b0, 16'h5A5A, 1'b0, a);
        in_valid = 1'b0;
        tick();
        check("rst_mid_in_low", lcd_wr_n, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_state("rst_mid");
        reset = 1'b0;
        tick();
        check("rst_mid_ready", in_ready, 1'b1);
        cap_q.delete();
        send(1'b0, 16'h0077, 1'b1, a);
        in_valid = 1'b0;
        check("post_rst_cs",   lcd_cs_n, 1'b0);
        check("post_rst_wr",   lcd_wr_n, 1'b1);
        check("post_rst_data", lcd_data, 16'h0077);
        tick();
        check("post_rst_low",  lcd_wr_n, 1'b0);
        tick(); tick();
        check("post_rst_high", lcd_wr_n, 1'b1);
        check("post_rst_count", words_written, 32'd1);
        repeat (6) tick();
        check("post_rst_idle", lcd_cs_n, 1'b1);
        check("post_rst_caps", cap_q.size(), 32'd1);
        if (cap_q.size() > 0) check("post_rst_cap0", 32'(cap_q[0]), 32'h10077);

        // ---- CNT_W=4 wrap, T_SETUP=3 / T_WR_LOW=1 / T_WR_HIGH=1 ----
        strobes_b = 0;
        low_b     = 0;
        for (int i = 0; i < 17; i++) begin
            send(1'b1, 16'(i), 1'b1, a);
            acc2[i] = a;
        end
        in_valid_b = 1'b0;
        repeat (12) tick();
        check("b_count_wrap", words_written_b, 4'd1);
        check("b_strobes",    strobes_b, 32'd17);
        check("b_low_cycles", low_b,     32'd17);
        check("b_cs_release", lcd_cs_n_b, 1'b1);
        for (int i = 1; i < 17; i++)
            check($sformatf("b_period_%0d", i), 32'(acc2[i] - acc2[i-1]), 32'd6);

        check("bus_stable_while_low", bad_change, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
